// File: rtl/ecc_pkg.sv
// Shared types for the ECC scalar-multiplication control path: FSM states
// and point-unit operation selects.
package ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    NEXT,
    DBL_REQ,
    DBL_WAIT,
    ADD_REQ,
    ADD_WAIT,
    FIN
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_DBL = 1'b1;

endpackage

// File: rtl/scalar_mult_ctrl_bit_iter.sv
// Holds the latched scalar and walks its bit index from KW-1 down to 0,
// presenting the bit under the index and a flag for the final position.
module scalar_bit_iter #(
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [KW-1:0] k_in,
  output logic          cur_bit,
  output logic          last
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  logic [KW-1:0] k_q, k_d;
  logic [IW-1:0] idx_q, idx_d;

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    k_d   = k_q;
    idx_d = idx_q;
    if (load) begin
      k_d   = k_in;
      idx_d = IW'(KW - 1);
    end else if (dec && (idx_q != '0)) begin
      idx_d = idx_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q   <= '0;
      idx_q <= '0;
    end else begin
      k_q   <= k_d;
      idx_q <= idx_d;
    end
  end

  assign cur_bit = k_q[idx_q];
  assign last    = (idx_q == '0);

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P, driving a shared
// add/double point unit through a start/done handshake.
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int N  = 231,
  parameter int KW = N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [N-1:0]  px,
  input  logic [N-1:0]  py,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  qx,
  output logic [N-1:0]  qy,
  output logic          q_inf,
  output logic          op_start,
  output logic          op_sel,
  output logic [N-1:0]  ax,
  output logic [N-1:0]  ay,
  output logic          a_inf,
  output logic [N-1:0]  bx,
  output logic [N-1:0]  by,
  output logic          b_inf,
  input  logic [N-1:0]  rx,
  input  logic [N-1:0]  ry,
  input  logic          r_inf,
  input  logic          op_done
);

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
  } point_t;

  state_t       state_q, state_d;
  point_t       acc_q, acc_d;
  point_t       q_q, q_d;
  logic [N-1:0] bx_q, bx_d, by_q, by_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         op_start_q, op_start_d;
  logic         op_sel_q, op_sel_d;

  logic iter_load, iter_dec, cur_bit, last;

  scalar_bit_iter #(.KW(KW)) u_bit_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (iter_load),
    .dec     (iter_dec),
    .k_in    (k),
    .cur_bit (cur_bit),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    bx_d      = bx_q;
    by_d      = by_q;
    op_sel_d  = op_sel_q;
    iter_load = 1'b0;
    iter_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bx_d      = px;
          by_d      = py;
          acc_d.inf = 1'b1;
          iter_load = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // The leading 1 seeds the accumulator with P directly; no point op is spent on it.
        if (cur_bit) begin
          acc_d   = '{x: bx_q, y: by_q, inf: 1'b0};
          state_d = NEXT;
        end else if (last) begin
          state_d = FIN;
        end else begin
          iter_dec = 1'b1;
        end
      end
      NEXT: begin
        if (last) begin
          state_d = FIN;
        end else begin
          iter_dec = 1'b1;
          op_sel_d = OP_DBL;
          state_d  = DBL_REQ;
        end
      end
      DBL_REQ: state_d = DBL_WAIT;
      DBL_WAIT: begin
        if (op_done) begin
          acc_d = '{x: rx, y: ry, inf: r_inf};
          if (cur_bit) begin
            op_sel_d = OP_ADD;
            state_d  = ADD_REQ;
          end else begin
            state_d = NEXT;
          end
        end
      end
      ADD_REQ: state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (op_done) begin
          acc_d   = '{x: rx, y: ry, inf: r_inf};
          state_d = NEXT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Capture the result on entry to FIN so q is already valid while done is high.
    if (state_d == FIN) begin
      q_d = acc_q;
    end

    busy_d     = (state_d != IDLE) && (state_d != FIN);
    done_d     = (state_d == FIN);
    op_start_d = (state_d == DBL_REQ) || (state_d == ADD_REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      q_q        <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_start_q <= 1'b0;
      op_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_start_q <= op_start_d;
      op_sel_q   <= op_sel_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign qx       = q_q.x;
  assign qy       = q_q.y;
  assign q_inf    = q_q.inf;
  assign op_start = op_start_q;
  assign op_sel   = op_sel_q;
  assign ax       = acc_q.x;
  assign ay       = acc_q.y;
  assign a_inf    = acc_q.inf;
  assign bx       = bx_q;
  assign by       = by_q;
  assign b_inf    = 1'b0;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Self-checking bench for scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17 with
// a behavioural point unit of programmable latency and a repeated-addition reference.
module tb_scalar_mult_ctrl;

  localparam int N       = 8;
  localparam int KW      = 8;
  localparam int PRIME   = 17;
  localparam int CURVE_A = 2;
  localparam logic DBL   = 1'b1;
  localparam logic ADD   = 1'b0;

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
  } pt_t;

  localparam pt_t P = '{x: 8'd5, y: 8'd1, inf: 1'b0};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k = '0;
  logic [N-1:0]  px = '0, py = '0;
  logic          busy, done, q_inf, op_start, op_sel, a_inf, b_inf;
  logic [N-1:0]  qx, qy, ax, ay, bx, by;
  logic [N-1:0]  rx = '0, ry = '0;
  logic          r_inf = 1'b0;
  logic          pu_done = 1'b0, spurious_done = 1'b0;
  logic          op_done;

  assign op_done = pu_done | spurious_done;

  int compared = 0;
  int mismatched = 0;
  int lat_cfg = 1;
  int op_count = 0;
  int pu_err = 0;
  logic pu_sel_log[$];
  pt_t  pu_a_log[$];
  pt_t  pu_b_log[$];

  scalar_mult_ctrl #(.N(N), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
    .op_start(op_start), .op_sel(op_sel), .ax(ax), .ay(ay), .a_inf(a_inf),
    .bx(bx), .by(by), .b_inf(b_inf), .rx(rx), .ry(ry), .r_inf(r_inf),
    .op_done(op_done)
  );

  always #5 clk = ~clk;

  // ---------------- curve reference ----------------
  function automatic int md(int v);
    return ((v % PRIME) + PRIME) % PRIME;
  endfunction

  function automatic int inv(int a);
    int r = 0;
    for (int i = 1; i < PRIME; i++) if (md(a * i) == 1) r = i;
    return r;
  endfunction

  function automatic pt_t infinity();
    pt_t r = '0;
    r.inf = 1'b1;
    return r;
  endfunction

  function automatic pt_t ec_dbl(pt_t a);
    int x1 = int'(a.x), y1 = int'(a.y), lam, x3, y3;
    pt_t r;
    if (a.inf || y1 == 0) return infinity();
    lam = md((3 * x1 * x1 + CURVE_A) * inv(2 * y1));
    x3  = md(lam * lam - 2 * x1);
    y3  = md(lam * (x1 - x3) - y1);
    r = '{x: N'(x3), y: N'(y3), inf: 1'b0};
    return r;
  endfunction

  function automatic pt_t ec_add(pt_t a, pt_t b);
    int x1 = int'(a.x), y1 = int'(a.y), x2 = int'(b.x), y2 = int'(b.y), lam, x3, y3;
    pt_t r;
    if (a.inf) return b;
    if (b.inf) return a;
    if (x1 == x2) begin
      if (md(y1 + y2) == 0) return infinity();
      return ec_dbl(a);
    end
    lam = md((y2 - y1) * inv(x2 - x1 + PRIME));
    x3  = md(lam * lam - x1 - x2);
    y3  = md(lam * (x1 - x3) - y1);
    r = '{x: N'(x3), y: N'(y3), inf: 1'b0};
    return r;
  endfunction

  // m*base by plain repeated addition
  function automatic pt_t ref_mult(int m, pt_t base);
    pt_t r = infinity();
    for (int i = 0; i < m; i++) r = ec_add(r, base);
    return r;
  endfunction

  function automatic int op_bad(int n, logic sel, int m, pt_t base);
    pt_t e;
    if (n >= pu_sel_log.size()) return 1;
    e = ref_mult(m, base);
    if (pu_sel_log[n] !== sel) return 1;
    if (pu_a_log[n].inf !== e.inf) return 1;
    if (!e.inf && (pu_a_log[n].x !== e.x || pu_a_log[n].y !== e.y)) return 1;
    if (pu_b_log[n].x !== base.x || pu_b_log[n].y !== base.y) return 1;
    return 0;
  endfunction

  // Number of logged point ops that differ from the double-and-add schedule for kv.
  function automatic int ops_deviation(logic [KW-1:0] kv, pt_t base);
    int msb = -1, m = 1, n = 0, bad = 0;
    for (int i = 0; i < KW; i++) if (kv[i]) msb = i;
    for (int i = msb - 1; i >= 0; i--) begin
      bad += op_bad(n, DBL, m, base);
      n++;
      m = 2 * m;
      if (kv[i]) begin
        bad += op_bad(n, ADD, m, base);
        n++;
        m++;
      end
    end
    if (pu_sel_log.size() != n) bad++;
    return bad;
  endfunction

  // ---------------- behavioural point unit ----------------
  initial begin : point_unit
    pt_t a, b, res;
    logic sel, aborted;
    @(posedge clk); #1;
    forever begin
      if (reset === 1'b1 && op_start === 1'b1) begin
        a   = '{x: ax, y: ay, inf: a_inf};
        b   = '{x: bx, y: by, inf: b_inf};
        sel = op_sel;
        op_count++;
        pu_sel_log.push_back(sel);
        pu_a_log.push_back(a);
        pu_b_log.push_back(b);
        if (b_inf !== 1'b0) pu_err++;
        res = sel ? ec_dbl(a) : ec_add(a, b);
        aborted = 1'b0;
        for (int c = 1; c <= lat_cfg; c++) begin
          @(posedge clk); #1;
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (op_start !== 1'b0 || op_sel !== sel || ax !== a.x || ay !== a.y ||
              a_inf !== a.inf || bx !== b.x || by !== b.y) pu_err++;
        end
        if (!aborted) begin
          rx = res.x; ry = res.y; r_inf = res.inf; pu_done = 1'b1;
          @(posedge clk); #1;
          pu_done = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    pu_sel_log.delete();
    pu_a_log.delete();
    pu_b_log.delete();
    op_count = 0;
  endtask

  task automatic run_job(input logic [KW-1:0] kv, input pt_t base, input int lat,
                         output int cycles, output logic first_busy);
    int budget = 40 + 2 * KW * (lat + 4);
    logic ok = 1'b0;
    clear_log();
    lat_cfg = lat;
    @(negedge clk);
    start = 1'b1; k = kv; px = base.x; py = base.y;
    @(negedge clk);
    start = 1'b0; k = KW'($urandom); px = N'($urandom); py = N'($urandom);
    first_busy = busy;
    cycles = 1;
    while (cycles < budget) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
      cycles++;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL job_timeout k=%0d: got no done within %0d cycles, want done", kv, budget);
    end
  endtask

  task automatic wait_ops(input int target);
    int n = 0;
    while (op_count < target && n < 2000) begin @(negedge clk); n++; end
    compared++;
    if (op_count < target) begin
      mismatched++;
      $display("FAIL op_wait: got %0d ops, want %0d", op_count, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, op_start, op_sel, q_inf, a_inf, b_inf} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 0000000", {busy, done, op_start, op_sel, q_inf, a_inf, b_inf});
    end
    compared++;
    if ({qx, qy, ax, ay, bx, by} !== '0) begin
      mismatched++;
      $display("FAIL reset_coords: got %h want 0", {qx, qy, ax, ay, bx, by});
    end
    reset = 1'b1;
  endtask

  task automatic test_k1();
    int cyc; logic fb;
    run_job(8'd1, P, 3, cyc, fb);
    compared++;
    if (fb !== 1'b1) begin mismatched++; $display("FAIL k1_busy_after_start: got %b want 1", fb); end
    compared++;
    if (cyc !== 10) begin mismatched++; $display("FAIL k1_latency: got %0d want 10", cyc); end
    compared++;
    if (op_count !== 0) begin mismatched++; $display("FAIL k1_ops: got %0d want 0", op_count); end
    compared++;
    if (qx !== 8'd5 || qy !== 8'd1 || q_inf !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL k1_result: got (%0d,%0d,inf=%b,busy=%b) want (5,1,inf=0,busy=0)", qx, qy, q_inf, busy);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL k1_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_k9();
    int cyc, err0, dev; logic fb;
    err0 = pu_err;
    run_job(8'd9, P, 4, cyc, fb);
    dev = ops_deviation(8'd9, P);
    compared++;
    if (dev !== 0) begin mismatched++; $display("FAIL k9_op_sequence: got %0d deviations want 0", dev); end
    compared++;
    if (pu_sel_log.size() != 4 || pu_sel_log[0] !== DBL || pu_sel_log[1] !== DBL ||
        pu_sel_log[2] !== DBL || pu_sel_log[3] !== ADD) begin
      mismatched++;
      $display("FAIL k9_op_order: got %0d ops want DBL,DBL,DBL,ADD", pu_sel_log.size());
    end
    compared++;
    if (pu_err !== err0) begin mismatched++; $display("FAIL k9_operand_stability: got %0d errors want 0", pu_err - err0); end
    compared++;
    if (qx !== 8'd7 || qy !== 8'd6 || q_inf !== 1'b0) begin
      mismatched++;
      $display("FAIL k9_result: got (%0d,%0d,inf=%b) want (7,6,inf=0)", qx, qy, q_inf);
    end
  endtask

  task automatic test_infinity();
    int cyc, dev, ainf_ops; logic fb; pt_t e;
    logic [KW-1:0] ks[3] = '{8'd19, 8'd20, 8'd39};
    foreach (ks[j]) begin
      run_job(ks[j], P, 2, cyc, fb);
      e = ref_mult(int'(ks[j]), P);
      compared++;
      if (q_inf !== e.inf || (!e.inf && (qx !== e.x || qy !== e.y))) begin
        mismatched++;
        $display("FAIL inf_result k=%0d: got (%0d,%0d,inf=%b) want (%0d,%0d,inf=%b)", ks[j], qx, qy, q_inf, e.x, e.y, e.inf);
      end
      dev = ops_deviation(ks[j], P);
      compared++;
      if (dev !== 0) begin mismatched++; $display("FAIL inf_ops k=%0d: got %0d deviations want 0", ks[j], dev); end
    end
    ainf_ops = 0;
    foreach (pu_a_log[n]) if (pu_a_log[n].inf) ainf_ops++;
    compared++;
    if (ainf_ops !== 2 || qx !== 8'd5 || qy !== 8'd1) begin
      mismatched++;
      $display("FAIL k39_a_inf_ops: got %0d ops with a_inf, Q=(%0d,%0d) want 2, Q=(5,1)", ainf_ops, qx, qy);
    end
  endtask

  task automatic test_k0();
    int cyc; logic fb;
    run_job(8'd0, P, 1, cyc, fb);
    compared++;
    if (cyc !== 9 || op_count !== 0 || q_inf !== 1'b1) begin
      mismatched++;
      $display("FAIL k0_result: got cycles=%0d ops=%0d inf=%b want cycles=9 ops=0 inf=1", cyc, op_count, q_inf);
    end
  endtask

  task automatic test_ignored_and_reset();
    int cyc, n; logic fb; pt_t e2;
    run_job(8'd2, P, 2, cyc, fb);
    e2 = ref_mult(2, P);
    @(negedge clk);
    spurious_done = 1'b1;
    @(negedge clk);
    spurious_done = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || op_start !== 1'b0 || ax !== e2.x || ay !== e2.y || a_inf !== 1'b0) begin
      mismatched++;
      $display("FAIL spurious_op_done: got busy=%b done=%b A=(%0d,%0d,%b) want 0,0,(%0d,%0d,0)", busy, done, ax, ay, a_inf, e2.x, e2.y);
    end

    // start pulsed while a double is outstanding
    clear_log();
    lat_cfg = 6;
    start = 1'b1; k = 8'd9; px = P.x; py = P.y;
    @(negedge clk);
    start = 1'b0;
    wait_ops(1);
    @(negedge clk);
    start = 1'b1; k = 8'd1; px = 8'd6; py = 8'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    compared++;
    if (done !== 1'b1 || qx !== 8'd7 || qy !== 8'd6 || q_inf !== 1'b0 || op_count !== 4) begin
      mismatched++;
      $display("FAIL start_while_busy: got done=%b Q=(%0d,%0d,%b) ops=%0d want 1,(7,6,0),4", done, qx, qy, q_inf, op_count);
    end

    // reset asserted while the final add is outstanding
    @(negedge clk);
    clear_log();
    start = 1'b1; k = 8'd9; px = P.x; py = P.y;
    @(negedge clk);
    start = 1'b0;
    wait_ops(4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if ({busy, done, op_start, op_sel, q_inf, a_inf, b_inf} !== 7'b0 || {qx, qy, ax, ay, bx, by} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_op: got flags=%b coords=%h want all 0",
               {busy, done, op_start, op_sel, q_inf, a_inf, b_inf}, {qx, qy, ax, ay, bx, by});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_job(8'd2, P, 3, cyc, fb);
    compared++;
    if (qx !== 8'd6 || qy !== 8'd3 || q_inf !== 1'b0) begin
      mismatched++;
      $display("FAIL k2_after_reset: got (%0d,%0d,inf=%b) want (6,3,inf=0)", qx, qy, q_inf);
    end
  endtask

  task automatic test_latency();
    int cyc; logic fb; pt_t q1, q40, e;
    run_job(8'd255, P, 1, cyc, fb);
    q1 = '{x: qx, y: qy, inf: q_inf};
    run_job(8'd255, P, 40, cyc, fb);
    q40 = '{x: qx, y: qy, inf: q_inf};
    e = ref_mult(255, P);
    compared++;
    if (q1 !== q40 || q40.inf !== e.inf || (!e.inf && (q40.x !== e.x || q40.y !== e.y))) begin
      mismatched++;
      $display("FAIL latency_result: got lat1=(%0d,%0d,%b) lat40=(%0d,%0d,%b) want (%0d,%0d,%b)",
               q1.x, q1.y, q1.inf, q40.x, q40.y, q40.inf, e.x, e.y, e.inf);
    end
    compared++;
    if (op_count !== 14) begin mismatched++; $display("FAIL k255_op_count: got %0d want 14", op_count); end
  endtask

  task automatic test_random();
    int cyc, j, dev, err0; logic fb; logic [KW-1:0] kv; pt_t base, e;
    for (int t = 0; t < 10; t++) begin
      err0 = pu_err;
      kv   = KW'($urandom_range(0, 255));
      j    = $urandom_range(1, 18);
      base = ref_mult(j, P);
      run_job(kv, base, $urandom_range(1, 5), cyc, fb);
      e   = ref_mult(int'(kv), base);
      dev = ops_deviation(kv, base);
      compared++;
      if (q_inf !== e.inf || (!e.inf && (qx !== e.x || qy !== e.y)) || dev !== 0 || pu_err !== err0) begin
        mismatched++;
        $display("FAIL random k=%0d base=%0dP: got (%0d,%0d,%b) dev=%0d perr=%0d want (%0d,%0d,%b) dev=0 perr=0",
                 kv, j, qx, qy, q_inf, dev, pu_err - err0, e.x, e.y, e.inf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_k1();
    test_k9();
    test_infinity();
    test_k0();
    test_ignored_and_reset();
    test_latency();
    test_random();
    compared++;
    if (pu_err !== 0) begin mismatched++; $display("FAIL point_unit_protocol: got %0d errors want 0", pu_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
